// File: rtl/img_frame_sched_pkg.sv
// Shared types and helpers for the frame-buffer slot scheduler.
package img_frame_sched_pkg;

    localparam int SLOT_IDX_W = 3;
    localparam int TYPE_W     = 2;
    localparam int DESC_W     = SLOT_IDX_W + TYPE_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_COMMIT = 3'd4,
        ST_ABORT  = 3'd5
    } state_t;

    typedef struct packed {
        logic [SLOT_IDX_W-1:0] slot;
        logic [TYPE_W-1:0]     ftype;
        logic                  ovf;
    } desc_t;

    // Shift-add is enough because the slot index is at most 3 bits wide.
    function automatic logic [31:0] slot_addr(input logic [31:0]           base,
                                              input logic [31:0]           size,
                                              input logic [SLOT_IDX_W-1:0] slot);
        logic [31:0] acc;
        acc = base;
        for (int b = 0; b < SLOT_IDX_W; b++) begin
            if (slot[b]) acc = acc + (size << b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/img_desc_fifo.sv
// First-word-fall-through FIFO carrying ready descriptors to the consumer.
module img_desc_fifo
    import img_frame_sched_pkg::*;
#(
    parameter int WIDTH = DESC_W,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign valid   = (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/img_frame_sched.sv
// Allocates a DDR slot per camera frame, drives datamover and packetizer, and posts ready descriptors.
//  state  | meaning
//  IDLE   | waiting for a frame-start edge; allocate or drop
//  CMD    | datamover write command offered
//  START  | packetizer started, watchdog loaded
//  RUN    | waiting for packet-done and write-done
//  COMMIT | push descriptor
//  ABORT  | free slot, count error
module img_frame_sched
    import img_frame_sched_pkg::*;
#(
    parameter int          NUM_SLOTS = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SLOT_SIZE = 32'h0010_0400,
    parameter logic [31:0] TMO_CYC   = 32'd4000000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_fs,
    input  logic [1:0]  cam_type,
    output logic        pk_frame_start,
    output logic [1:0]  pk_frame_type,
    input  logic        pk_frame_store,
    input  logic        pk_overflow,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_addr,
    output logic [22:0] cmd_btt,
    input  logic        wr_done,
    input  logic        wr_err,
    output logic        rdy_valid,
    input  logic        rdy_ready,
    output logic [2:0]  rdy_slot,
    output logic [31:0] rdy_addr,
    output logic [1:0]  rdy_type,
    output logic        rdy_ovf,
    input  logic        rel_valid,
    input  logic [2:0]  rel_slot,
    output logic [7:0]  busy_map,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [7:0] SLOT_MASK = 8'((32'd1 << NUM_SLOTS) - 32'd1);

    state_t      state, state_nx;
    logic        fs_q1, fs_q2, fs_edge;
    logic [1:0]  type_q1, type_q;
    logic [2:0]  slot_q;
    logic        pk_done, dm_done, pk_done_nx, dm_done_nx;
    logic [31:0] wd;
    logic [7:0]  busy, busy_nx, free_map;
    logic        free_any;
    logic [2:0]  free_idx;
    logic        alloc, drop, push, abort_fr;
    desc_t       push_desc, head_desc;
    logic        head_valid;

    assign fs_edge = fs_q1 & ~fs_q2;

    always_comb begin
        free_map = ~busy & SLOT_MASK;
        free_any = |free_map;
        free_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (free_map[i]) free_idx = 3'(i);
        end
    end

    always_comb begin
        state_nx   = state;
        alloc      = 1'b0;
        drop       = 1'b0;
        push       = 1'b0;
        abort_fr   = 1'b0;
        pk_done_nx = pk_done | pk_frame_store;
        dm_done_nx = dm_done | (wr_done & ~wr_err);
        case (state)
            ST_IDLE: begin
                if (fs_edge) begin
                    if (free_any) begin
                        alloc    = 1'b1;
                        state_nx = ST_CMD;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_CMD:   if (cmd_ready) state_nx = ST_START;
            ST_START: state_nx = ST_RUN;
            ST_RUN: begin
                if (wr_done & wr_err)            state_nx = ST_ABORT;
                else if (pk_done_nx & dm_done_nx) state_nx = ST_COMMIT;
                else if (wd == '0)                state_nx = ST_ABORT;
            end
            ST_COMMIT: begin
                push     = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_ABORT: begin
                abort_fr = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Allocation sees the pre-release map; a release aimed at a free slot is a no-op.
    always_comb begin
        busy_nx = busy;
        if (rel_valid) busy_nx[rel_slot] = 1'b0;
        if (abort_fr)  busy_nx[slot_q]   = 1'b0;
        if (alloc)     busy_nx[free_idx] = 1'b1;
        busy_nx = busy_nx & SLOT_MASK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fs_q1    <= 1'b0;
            fs_q2    <= 1'b0;
            type_q1  <= '0;
            type_q   <= '0;
            slot_q   <= '0;
            pk_done  <= 1'b0;
            dm_done  <= 1'b0;
            wd       <= '0;
            busy     <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state   <= state_nx;
            fs_q1   <= cam_fs;
            fs_q2   <= fs_q1;
            type_q1 <= cam_type;
            busy    <= busy_nx;
            if (alloc) begin
                slot_q  <= free_idx;
                type_q  <= type_q1;
                pk_done <= 1'b0;
                dm_done <= 1'b0;
            end else if (state == ST_RUN) begin
                pk_done <= pk_done_nx;
                dm_done <= dm_done_nx;
            end
            if (state == ST_START)                 wd <= TMO_CYC - 32'd1;
            else if (state == ST_RUN && wd != '0) wd <= wd - 32'd1;
            if (drop && drop_cnt != 16'hFFFF)     drop_cnt <= drop_cnt + 16'd1;
            if (abort_fr && err_cnt != 16'hFFFF)  err_cnt <= err_cnt + 16'd1;
        end
    end

    assign push_desc = '{slot: slot_q, ftype: type_q, ovf: pk_overflow};

    img_desc_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (NUM_SLOTS)
    ) u_desc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_desc),
        .pop   (rdy_ready),
        .dout  (head_desc),
        .valid (head_valid)
    );

    assign pk_frame_start = (state == ST_START) || (state == ST_RUN);
    assign pk_frame_type  = type_q;
    assign cmd_valid      = (state == ST_CMD);
    assign cmd_addr       = cmd_valid ? slot_addr(BASE_ADDR, SLOT_SIZE, slot_q) : '0;
    assign cmd_btt        = cmd_valid ? SLOT_SIZE[22:0] : '0;
    assign rdy_valid      = head_valid;
    assign rdy_slot       = head_valid ? head_desc.slot : '0;
    assign rdy_type       = head_valid ? head_desc.ftype : '0;
    assign rdy_ovf        = head_valid & head_desc.ovf;
    assign rdy_addr       = head_valid ? slot_addr(BASE_ADDR, SLOT_SIZE, head_desc.slot) : '0;
    assign busy_map       = busy;

endmodule

// File: tb/tb_img_frame_sched.sv
// Directed and randomized frames against a slot/queue/counter model of the scheduler.
module tb_img_frame_sched;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SIZE = 32'h0010_0400;
    localparam logic [31:0] TMO  = 32'd300;

    logic        clk, rst_n, cam_fs, pk_frame_start, pk_frame_store, pk_overflow;
    logic [1:0]  cam_type, pk_frame_type, rdy_type;
    logic        cmd_valid, cmd_ready, wr_done, wr_err, rdy_valid, rdy_ready, rdy_ovf, rel_valid;
    logic [31:0] cmd_addr, rdy_addr;
    logic [22:0] cmd_btt;
    logic [2:0]  rdy_slot, rel_slot;
    logic [7:0]  busy_map;
    logic [15:0] drop_cnt, err_cnt;

    img_frame_sched #(.NUM_SLOTS(NS), .BASE_ADDR(BASE), .SLOT_SIZE(SIZE), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cam_fs(cam_fs), .cam_type(cam_type),
        .pk_frame_start(pk_frame_start), .pk_frame_type(pk_frame_type),
        .pk_frame_store(pk_frame_store), .pk_overflow(pk_overflow),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_btt(cmd_btt),
        .wr_done(wr_done), .wr_err(wr_err),
        .rdy_valid(rdy_valid), .rdy_ready(rdy_ready), .rdy_slot(rdy_slot), .rdy_addr(rdy_addr),
        .rdy_type(rdy_type), .rdy_ovf(rdy_ovf), .rel_valid(rel_valid), .rel_slot(rel_slot),
        .busy_map(busy_map), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int slot; int ftype; int ovf;} exp_desc_t;

    int        checks = 0;
    int        failures = 0;
    bit        m_busy [NS];
    int        m_drop, m_err;
    exp_desc_t m_q [$];
    int        held [$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_map();
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < NS; i++) m[i] = m_busy[i];
        return m;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < NS; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] exp_addr(input int s);
        return BASE + 32'(s) * SIZE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
        m_drop = 0;
        m_err  = 0;
        m_q.delete();
        held.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, {cmd_addr, rdy_addr}, 64'd0);
        check({tag, "_ctl"}, {pk_frame_start, pk_frame_type, cmd_valid, cmd_btt, rdy_valid,
                              rdy_slot, rdy_type, rdy_ovf}, 64'd0);
        check({tag, "_stat"}, {busy_map, drop_cnt, err_cnt}, 64'd0);
    endtask

    task automatic release_slot(input int s);
        rel_valid = 1'b1;
        rel_slot  = 3'(s);
        tick(1);
        rel_valid = 1'b0;
        if (s < NS) m_busy[s] = 1'b0;
        check("rel_busy", busy_map, model_map());
    endtask

    task automatic pop_one(input bit do_rel);
        exp_desc_t e;
        if (m_q.size() == 0) begin
            check("rdy_empty", rdy_valid, 0);
            return;
        end
        e = m_q.pop_front();
        check("rdy_valid", rdy_valid, 1);
        check("rdy_slot", rdy_slot, e.slot);
        check("rdy_type", rdy_type, e.ftype);
        check("rdy_ovf", rdy_ovf, e.ovf);
        check("rdy_addr", rdy_addr, exp_addr(e.slot));
        rdy_ready = 1'b1;
        tick(1);
        rdy_ready = 1'b0;
        if (do_rel) release_slot(e.slot);
        else        held.push_back(e.slot);
    endtask

    // mode: 0 commit, 1 write error, 2 watchdog, 3 reset while running
    task automatic frame(input logic [1:0] typ, input int mode, input int dpk, input int dwr,
                         input int cdly, input bit ovf, input int rel_s);
        int s, n;
        bit seen;
        s = lowest_free();
        cam_type = typ;
        cam_fs   = 1'b1;
        tick(1);
        if (rel_s >= 0) begin
            rel_valid = 1'b1;
            rel_slot  = 3'(rel_s);
        end
        tick(1);
        rel_valid = 1'b0;
        if (rel_s >= 0 && rel_s < NS) m_busy[rel_s] = 1'b0;
        if (s < 0) begin
            m_drop++;
            tick(3);
            check("drop_no_cmd", cmd_valid, 0);
            check("drop_cnt", drop_cnt, m_drop);
            cam_fs = 1'b0;
            tick(3);
            check("drop_busy", busy_map, model_map());
            return;
        end
        m_busy[s] = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 8) begin
            if (cmd_valid) seen = 1'b1;
            else begin tick(1); n++; end
        end
        check("cmd_valid_rise", seen, 1);
        check("cmd_addr", cmd_addr, exp_addr(s));
        check("cmd_btt", cmd_btt, SIZE & 32'h007F_FFFF);
        check("busy_alloc", busy_map, model_map());
        cam_fs = 1'b0;
        if (cdly > 0) begin
            tick(cdly);
            check("cmd_hold_valid", cmd_valid, 1);
            check("cmd_hold_addr", cmd_addr, exp_addr(s));
        end
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check("pk_start", pk_frame_start, 1);
        check("pk_type", pk_frame_type, typ);
        pk_overflow = ovf;
        tick(1);
        if (mode == 3) begin
            tick(5);
            check("pk_start_run", pk_frame_start, 1);
            rst_n = 1'b0;
            tick(1);
            check_zero("rst_mid");
            rst_n = 1'b1;
            pk_overflow = 1'b0;
            model_reset();
            tick(2);
            return;
        end
        n = (mode == 2) ? int'(TMO) + 4 : ((dpk > dwr) ? dpk : dwr);
        for (int c = 0; c <= n; c++) begin
            pk_frame_store = (c == dpk);
            wr_done        = (mode != 2 && c == dwr);
            wr_err         = (mode == 1 && c == dwr);
            tick(1);
        end
        pk_frame_store = 1'b0;
        wr_done = 1'b0;
        wr_err  = 1'b0;
        tick(3);
        pk_overflow = 1'b0;
        if (mode == 0) m_q.push_back('{s, int'(typ), int'(ovf)});
        else begin
            m_busy[s] = 1'b0;
            m_err++;
        end
        check("pk_start_low", pk_frame_start, 0);
        check("frame_busy", busy_map, model_map());
        check("err_cnt", err_cnt, m_err);
        check("rdy_pending", rdy_valid, m_q.size() != 0);
    endtask

    initial begin
        int r, s;
        rst_n = 1'b0; cam_fs = 1'b0; cam_type = '0; pk_frame_store = 1'b0; pk_overflow = 1'b0;
        cmd_ready = 1'b0; wr_done = 1'b0; wr_err = 1'b0; rdy_ready = 1'b0;
        rel_valid = 1'b0; rel_slot = '0;
        model_reset();
        tick(3);
        check_zero("reset");
        rst_n = 1'b1;
        tick(2);

        frame(2'b01, 0, 100, 120, 0, 1'b0, -1);
        pop_one(1'b1);

        for (int i = 0; i < 4; i++) frame(2'(i), 0, 5 + i, 3, 0, (i == 2), -1);
        frame(2'b11, 0, 3, 3, 0, 1'b0, -1);
        check("drop_after_exhaust", drop_cnt, 16'd1);
        for (int i = 0; i < 4; i++) pop_one(1'b0);

        s = held[2];
        held.delete(2);
        release_slot(s);
        frame(2'b10, 0, 4, 4, 0, 1'b0, -1);
        check("busy_full", busy_map, 8'h0F);
        pop_one(1'b0);
        while (held.size() > 0) release_slot(held.pop_front());

        frame(2'b01, 1, 3, 6, 0, 1'b0, -1);
        check("err_after_wrerr", err_cnt, 16'd1);
        frame(2'b10, 2, 5, 0, 0, 1'b0, -1);
        check("err_after_tmo", err_cnt, 16'd2);

        frame(2'b11, 0, 40, 10, 50, 1'b1, -1);
        pop_one(1'b1);
        for (int i = 0; i < 3; i++) frame(2'(i + 1), 0, 2 + i, 7, 0, 1'b0, -1);
        for (int i = 0; i < 3; i++) pop_one(1'b1);

        frame(2'b01, 3, 0, 0, 0, 1'b0, -1);
        frame(2'b00, 0, 4, 6, 0, 1'b0, -1);
        pop_one(1'b0);
        held.delete();
        frame(2'b10, 0, 3, 3, 0, 1'b0, 0);
        check("rel_alloc_same", busy_map, 8'h02);
        pop_one(1'b1);

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                int m, x, rs;
                x  = $urandom_range(0, 19);
                m  = (x == 0) ? 2 : ((x < 3) ? 1 : 0);
                rs = -1;
                if (held.size() > 0 && $urandom_range(0, 3) == 0) rs = held.pop_front();
                frame(2'($urandom_range(0, 3)), m, $urandom_range(0, 30), $urandom_range(0, 30),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), rs);
            end else if (r <= 6) begin
                pop_one(1'($urandom_range(0, 1)));
            end else if (r <= 8) begin
                if (held.size() > 0) release_slot(held.pop_front());
                else begin
                    s = $urandom_range(0, 7);
                    if (s < NS && m_busy[s]) s = s + NS;
                    release_slot(s);
                end
            end else begin
                tick($urandom_range(0, 5));
            end
        end

        while (m_q.size() > 0) pop_one(1'b1);
        while (held.size() > 0) release_slot(held.pop_front());
        check("final_busy", busy_map, 8'h00);
        check("final_drop", drop_cnt, m_drop);
        check("final_err", err_cnt, m_err);
        check("final_rdy", rdy_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
